// File: rtl/k_fifo_2deep_ctrl_pkg.sv
// Shared sizing constants for the 2-deep FIFO controller and anything that
// needs to agree with its default geometry.
package k_fifo_2deep_ctrl_pkg;

    localparam int default_data_size = 8;
    localparam int default_addr_size = 1;
    localparam int depth             = 1 << default_addr_size;

endpackage

// File: rtl/k_fifo_2deep_ctrl_ram.sv
// Small dual-port RAM used as FIFO storage: synchronous write, combinational
// read so the head entry is visible without a read-latency cycle.
module k_fifo_2deep_ctrl_ram
    import k_fifo_2deep_ctrl_pkg::*;
#(
    parameter int data_size = default_data_size,
    parameter int addr_size = default_addr_size
) (
    input  logic                 clk,
    input  logic                 wen,
    input  logic [addr_size-1:0] waddr,
    input  logic [addr_size-1:0] raddr,
    input  logic [data_size-1:0] d,
    output logic [data_size-1:0] q
);

    logic [data_size-1:0] mem [0:(1<<addr_size)-1];

    // Contents are deliberately not reset; the FIFO flags say what is valid.
    always_ff @(posedge clk) begin
        if (wen) begin
            mem[waddr] <= d;
        end
    end

    assign q = mem[raddr];

endmodule

// File: rtl/k_fifo_2deep_ctrl.sv
// Synchronous FIFO controller with valid/ready on both sides. Pointers carry
// one extra wrap bit so full and empty are distinguishable without a counter.
module k_fifo_2deep_ctrl
    import k_fifo_2deep_ctrl_pkg::*;
#(
    parameter int data_size = default_data_size,
    parameter int addr_size = default_addr_size
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic [data_size-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [data_size-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [addr_size:0]   count,
    output logic                 full,
    output logic                 empty
);

    localparam logic [addr_size:0] ptr_one = 1;

    logic [addr_size:0] wptr;
    logic [addr_size:0] rptr;
    logic               push;
    logic               pop;
    logic               wen;

    assign empty     = (wptr == rptr);
    assign full      = (wptr[addr_size-1:0] == rptr[addr_size-1:0]) &&
                       (wptr[addr_size] != rptr[addr_size]);
    assign count     = wptr - rptr;
    assign out_valid = !empty;
    assign in_ready  = rst_n && !full;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;
    // A flush discards the concurrent push, so the RAM write is gated too.
    assign wen  = push && !flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + ptr_one;
            end
            if (pop) begin
                rptr <= rptr + ptr_one;
            end
        end
    end

    k_fifo_2deep_ctrl_ram #(
        .data_size (data_size),
        .addr_size (addr_size)
    ) u_ram (
        .clk   (clk),
        .wen   (wen),
        .waddr (wptr[addr_size-1:0]),
        .raddr (rptr[addr_size-1:0]),
        .d     (in_data),
        .q     (out_data)
    );

endmodule

// File: tb/tb_k_fifo_2deep_ctrl.sv
// Directed self-checking bench for k_fifo_2deep_ctrl with hand-computed
// expectations for reset, fill/drain, streaming, full+pop, flush and reset.
module tb_k_fifo_2deep_ctrl;
    import k_fifo_2deep_ctrl_pkg::*;

    logic                         clk;
    logic                         rst_n;
    logic                         flush;
    logic [default_data_size-1:0] in_data;
    logic                         in_valid;
    logic                         in_ready;
    logic [default_data_size-1:0] out_data;
    logic                         out_valid;
    logic                         out_ready;
    logic [default_addr_size:0]   count;
    logic                         full;
    logic                         empty;

    int tests_run;
    int tests_failed;

    k_fifo_2deep_ctrl #(
        .data_size (default_data_size),
        .addr_size (default_addr_size)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic f, input logic iv,
                                 input logic [7:0] d, input logic ordy);
        rst_n     = r;
        flush     = f;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        // Reset held for two edges, then released
        applyStimulus(0, 0, 0, 8'h00, 0);
        tick();
        checkOutput("rst_in_ready_low", 32'(in_ready), 0);
        tick();
        checkOutput("rst_in_ready_low2", 32'(in_ready), 0);
        applyStimulus(1, 0, 0, 8'h00, 0);
        checkOutput("idle_in_ready", 32'(in_ready), 1);
        checkOutput("idle_empty", 32'(empty), 1);
        checkOutput("idle_full", 32'(full), 0);
        checkOutput("idle_count", 32'(count), 0);
        checkOutput("idle_out_valid", 32'(out_valid), 0);

        // Fill with A1, B2 then drain
        applyStimulus(1, 0, 1, 8'hA1, 0);
        tick();
        checkOutput("fill1_count", 32'(count), 1);
        checkOutput("fill1_out_valid", 32'(out_valid), 1);
        checkOutput("fill1_out_data", 32'(out_data), 32'hA1);
        applyStimulus(1, 0, 1, 8'hB2, 0);
        tick();
        checkOutput("fill2_full", 32'(full), 1);
        checkOutput("fill2_count", 32'(count), depth);
        checkOutput("fill2_in_ready", 32'(in_ready), 0);
        checkOutput("fill2_out_data", 32'(out_data), 32'hA1);
        applyStimulus(1, 0, 0, 8'h00, 1);
        tick();
        checkOutput("drain1_out_data", 32'(out_data), 32'hB2);
        checkOutput("drain1_count", 32'(count), 1);
        checkOutput("drain1_in_ready", 32'(in_ready), 1);
        tick();
        checkOutput("drain2_empty", 32'(empty), 1);
        checkOutput("drain2_count", 32'(count), 0);
        checkOutput("drain2_out_valid", 32'(out_valid), 0);

        // Streaming: preload 0x00, then push i / pop i-1 each cycle
        applyStimulus(1, 0, 1, 8'h00, 0);
        tick();
        checkOutput("stream_preload_count", 32'(count), 1);
        for (int i = 1; i < 16; i++) begin
            applyStimulus(1, 0, 1, 8'(i), 1);
            checkOutput("stream_out_data", 32'(out_data), 32'(i - 1));
            tick();
            checkOutput("stream_count", 32'(count), 1);
        end
        applyStimulus(1, 0, 0, 8'h00, 1);
        checkOutput("stream_last_data", 32'(out_data), 32'h0F);
        tick();
        checkOutput("stream_end_empty", 32'(empty), 1);

        // Full with simultaneous pop: the offered EE must not be taken
        applyStimulus(1, 0, 1, 8'hC3, 0);
        tick();
        applyStimulus(1, 0, 1, 8'hD4, 0);
        tick();
        checkOutput("fullpop_full", 32'(full), 1);
        applyStimulus(1, 0, 1, 8'hEE, 1);
        checkOutput("fullpop_in_ready", 32'(in_ready), 0);
        checkOutput("fullpop_head", 32'(out_data), 32'hC3);
        tick();
        checkOutput("fullpop_count", 32'(count), 1);
        checkOutput("fullpop_in_ready_next", 32'(in_ready), 1);
        checkOutput("fullpop_next_data", 32'(out_data), 32'hD4);
        applyStimulus(1, 0, 0, 8'h00, 1);
        tick();
        checkOutput("fullpop_drained", 32'(empty), 1);

        // Flush colliding with push and pop while one entry is held
        applyStimulus(1, 0, 1, 8'h55, 0);
        tick();
        checkOutput("flush_pre_count", 32'(count), 1);
        applyStimulus(1, 1, 1, 8'h66, 1);
        checkOutput("flush_in_ready", 32'(in_ready), 1);
        tick();
        checkOutput("flush_count", 32'(count), 0);
        checkOutput("flush_empty", 32'(empty), 1);
        // Slot 1 still holds D4 unless the flushed 66 leaked into the RAM
        applyStimulus(1, 0, 1, 8'h77, 0);
        tick();
        applyStimulus(1, 0, 0, 8'h00, 1);
        checkOutput("flush_after_push", 32'(out_data), 32'h77);
        tick();
        checkOutput("flush_no_write", 32'(out_data), 32'hD4);

        // Reset dropped for one cycle while full and pushing
        applyStimulus(1, 0, 1, 8'h11, 0);
        tick();
        applyStimulus(1, 0, 1, 8'h22, 0);
        tick();
        checkOutput("midrst_pre_count", 32'(count), 2);
        applyStimulus(0, 0, 1, 8'h33, 1);
        checkOutput("midrst_in_ready", 32'(in_ready), 0);
        tick();
        checkOutput("midrst_count", 32'(count), 0);
        applyStimulus(1, 0, 0, 8'h00, 0);
        checkOutput("midrst_empty", 32'(empty), 1);
        checkOutput("midrst_in_ready_after", 32'(in_ready), 1);
        applyStimulus(1, 0, 1, 8'h44, 0);
        tick();
        checkOutput("midrst_push_data", 32'(out_data), 32'h44);
        checkOutput("midrst_push_count", 32'(count), 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
